// File: rtl/alu_req_scheduler_pkg.sv
// alu_sched_pkg: shared types and constants for the ALU request scheduler.
//   state_t        scheduler FSM state (IDLE, ISSUE, RESP)
//   FLAG_W, OP_W   flag vector width and opcode width
//   PAR..LT        bit positions inside the {parity, overflow, greater, is_eq, less} flag vector
package alu_sched_pkg;

    localparam int FLAG_W = 5;
    localparam int OP_W   = 2;

    localparam int PAR = 4;
    localparam int OVF = 3;
    localparam int GT  = 2;
    localparam int EQ  = 1;
    localparam int LT  = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_req_scheduler_if.sv
// alu_req_scheduler_if: requester-side and ALU-side signals of the scheduler.
//   req_valid/req_ready/req_a/req_b/req_op  request channel, requester i at slice i
//   rsp_valid/rsp_ready/rsp_y/rsp_flags     response channel, rsp_y/rsp_flags shared
//   alu_a/alu_b/alu_op/alu_oe               operands driven into the shared ALU
//   alu_y, alu_parity..alu_less             combinational ALU result and flags
// Handshake rule for both channels: a transfer happens on a rising clk edge where
// valid and ready are both high for the same requester bit; the sender holds
// valid and payload stable until that edge, and ready may depend on valid.
// Modports: slave = the scheduler, master = requesters plus the ALU.
interface alu_req_scheduler_if import alu_sched_pkg::*; #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*W-1:0]    req_a;
    logic [NREQ*W-1:0]    req_b;
    logic [NREQ*OP_W-1:0] req_op;

    logic [NREQ-1:0]      rsp_valid;
    logic [NREQ-1:0]      rsp_ready;
    logic [W-1:0]         rsp_y;
    logic [FLAG_W-1:0]    rsp_flags;

    logic [W-1:0]         alu_a;
    logic [W-1:0]         alu_b;
    logic [OP_W-1:0]      alu_op;
    logic                 alu_oe;
    logic [W-1:0]         alu_y;
    logic                 alu_parity;
    logic                 alu_overflow;
    logic                 alu_greater;
    logic                 alu_is_eq;
    logic                 alu_less;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        input  alu_y, alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less,
        output req_ready, rsp_valid, rsp_y, rsp_flags,
        output alu_a, alu_b, alu_op, alu_oe
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        output alu_y, alu_parity, alu_overflow, alu_greater, alu_is_eq, alu_less,
        input  req_ready, rsp_valid, rsp_y, rsp_flags,
        input  alu_a, alu_b, alu_op, alu_oe
    );

endinterface

// File: rtl/alu_req_scheduler_rr_arbiter.sv
// rr_arbiter: purely combinational round-robin search.
//   req        request vector, one bit per requester
//   ptr        index where the search starts (highest priority)
//   grant      one-hot grant, zero when req is zero
//   grant_idx  encoded index of the granted bit, zero when nothing granted
module rr_arbiter #(
    parameter int NREQ  = 4,
    parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin : search
        logic             found;
        int               k;
        logic [IDX_W-1:0] kk;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        k         = 0;
        kk        = '0;
        for (int i = 0; i < NREQ; i++) begin
            // Walk NREQ positions starting at ptr, wrapping past the top.
            k = int'(ptr) + i;
            if (k >= NREQ) k = k - NREQ;
            kk = IDX_W'(k);
            if (!found && req[kk]) begin
                found     = 1'b1;
                grant[kk] = 1'b1;
                grant_idx = kk;
            end
        end
    end

endmodule

// File: rtl/alu_req_scheduler.sv
// alu_req_scheduler: shares one combinational ALU among NREQ requesters.
// A round-robin winner's operands are captured, held on the ALU for SETTLE
// cycles, the ALU result and flags are registered, then returned to the
// winner over the response channel.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         alu_req_scheduler_if slave: request, response and ALU ports
//   busy        high whenever the FSM is not IDLE
//   dbg_state   current FSM state
module alu_req_scheduler import alu_sched_pkg::*; #(
    parameter int NREQ   = 4,
    parameter int W      = 8,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    alu_req_scheduler_if.slave   bus,
    output logic                 busy,
    output state_t               dbg_state
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic [CNT_W-1:0]  cnt;
    logic [W-1:0]      a_q;
    logic [W-1:0]      b_q;
    logic [OP_W-1:0]   op_q;
    logic [W-1:0]      y_q;
    logic [FLAG_W-1:0] flags_q;

    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  next_ptr;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req       (bus.req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign next_ptr = (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            owner   <= '0;
            cnt     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            y_q     <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        a_q    <= bus.req_a[grant_idx*W +: W];
                        b_q    <= bus.req_b[grant_idx*W +: W];
                        op_q   <= bus.req_op[grant_idx*OP_W +: OP_W];
                        owner  <= grant_idx;
                        rr_ptr <= next_ptr;
                        cnt    <= CNT_W'(SETTLE - 1);
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    // ALU inputs have been stable for SETTLE cycles when cnt hits 0.
                    if (cnt == '0) begin
                        y_q          <= bus.alu_y;
                        flags_q[PAR] <= bus.alu_parity;
                        flags_q[OVF] <= bus.alu_overflow;
                        flags_q[GT]  <= bus.alu_greater;
                        flags_q[EQ]  <= bus.alu_is_eq;
                        flags_q[LT]  <= bus.alu_less;
                        state        <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    // Only the owner's ready bit completes the response.
                    if (bus.rsp_ready[owner]) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Grant is combinational from req_valid; rst_n gating keeps req_ready low
    // while reset is held even though the FSM already sits in IDLE.
    assign bus.req_ready = (state == IDLE && rst_n) ? grant : '0;
    assign bus.rsp_valid = (state == RESP) ? (NREQ'(1) << owner) : '0;
    assign bus.rsp_y     = y_q;
    assign bus.rsp_flags = flags_q;

    // Operands stay parked on the captured values so the ALU does not toggle when idle.
    assign bus.alu_a  = a_q;
    assign bus.alu_b  = b_q;
    assign bus.alu_op = op_q;
    assign bus.alu_oe = (state == ISSUE);

    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule
